// File: rtl/regfile_2r1w.sv
// Two-read / one-write register file with registered read ports and a post-reset zeroing sweep.
// Optional macro REGFILE_ZERO_REG_EN hard-wires entry 0 to read as zero.
module regfile_2r1w #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t            state;
  logic [ADDR_W:0]   clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_ok;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] rd0_nxt;
  logic [DATA_W-1:0] rd1_nxt;

`ifdef REGFILE_ZERO_REG_EN
  always_comb wr_ok = (waddr != '0);
`else
  always_comb wr_ok = 1'b1;
`endif

  // Sweep and user writes share the single write port; rst itself never touches the array.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = waddr;
    mem_wd = wdata;
    if (!rst) begin
      if (state == CLEAR) begin
        mem_we = 1'b1;
        mem_wa = clr_cnt[ADDR_W-1:0];
        mem_wd = '0;
      end else if (we && wr_ok) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  // Write-first bypass per port; wr_ok already excludes address 0 when it is hard-wired.
  always_comb begin
    rd0_nxt = mem[raddr0];
    rd1_nxt = mem[raddr1];
    if (we && wr_ok && (waddr == raddr0)) rd0_nxt = wdata;
    if (we && wr_ok && (waddr == raddr1)) rd1_nxt = wdata;
`ifdef REGFILE_ZERO_REG_EN
    if (raddr0 == '0) rd0_nxt = '0;
    if (raddr1 == '0) rd1_nxt = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      busy    <= 1'b1;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      case (state)
        CLEAR: begin
          rdata0  <= '0;
          rdata1  <= '0;
          clr_cnt <= clr_cnt + (ADDR_W+1)'(1);
          if (clr_cnt == {1'b0, {ADDR_W{1'b1}}}) begin
            state <= READY;
            busy  <= 1'b0;
          end
        end
        READY: begin
          rdata0 <= rd0_nxt;
          rdata1 <= rd1_nxt;
        end
        default: begin
          state <= CLEAR;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w: reference array model feeding an expected-value queue,
// plus a second small instance (DATA_W=8, ADDR_W=3).
module tb_regfile_2r1w;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, we, busy;
  logic [4:0]  waddr, raddr0, raddr1;
  logic [31:0] wdata, rdata0, rdata1;

  logic        s_rst, s_we, s_busy;
  logic [2:0]  s_waddr, s_ra0, s_ra1;
  logic [7:0]  s_wdata, s_rd0, s_rd1;

  regfile_2r1w dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr0(raddr0), .raddr1(raddr1), .rdata0(rdata0), .rdata1(rdata1), .busy(busy)
  );

  regfile_2r1w #(.DATA_W(8), .ADDR_W(3)) dut_s (
    .clk(clk), .rst(s_rst), .we(s_we), .waddr(s_waddr), .wdata(s_wdata),
    .raddr0(s_ra0), .raddr1(s_ra1), .rdata0(s_rd0), .rdata1(s_rd1), .busy(s_busy)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [32];
  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [4:0] a);
    if (ZERO && a == 5'd0) return 32'h0;
    return model[a];
  endfunction

  // One READY cycle: model applies the write first, so same-cycle reads see the new data.
  task automatic cycle(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a0, input logic [4:0] a1, input string tag);
    exp_t e;
    we = w; waddr = wa; wdata = wd; raddr0 = a0; raddr1 = a1;
    if (w && !(ZERO && wa == 5'd0)) model[wa] = wd;
    e.tag = tag; e.exp0 = model_rd(a0); e.exp1 = model_rd(a1);
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk({e.tag, ".rd0"}, rdata0, e.exp0);
    chk({e.tag, ".rd1"}, rdata1, e.exp1);
    chk({e.tag, ".busy"}, {31'b0, busy}, 32'h0);
  endtask

  task automatic sweep(input int unsigned exp_len, input string tag);
    int unsigned n = 0;
    while (busy === 1'b1 && n < exp_len + 8) begin
      @(posedge clk); #1;
      n++;
      chk({tag, ".rd0_held"}, rdata0, 32'h0);
    end
    chk({tag, ".busy_len"}, n, exp_len);
    foreach (model[i]) model[i] = 32'h0;
  endtask

  initial begin
    logic [4:0]  ra, rb, wa;
    logic [31:0] wd;
    int unsigned n;

    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr0 = '0; raddr1 = '0;
    s_rst = 1'b1; s_we = 1'b0; s_waddr = '0; s_wdata = '0; s_ra0 = '0; s_ra1 = '0;

    // Reset state over a two-cycle pulse
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("rst.busy", {31'b0, busy}, 32'h1);
      chk("rst.rd0", rdata0, 32'h0);
      chk("rst.rd1", rdata1, 32'h0);
    end

    // Sweep with a write to an early-cleared entry held the whole time; it must be ignored
    rst = 1'b0; we = 1'b1; waddr = 5'd2; wdata = 32'hBAD0BAD0; raddr0 = 5'd2;
    sweep(32, "sweep0");
    we = 1'b0;

    for (int i = 0; i < 32; i++) begin
      cycle(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), "clear_rd");
    end

    cycle(1'b1, 5'd7, 32'hDEADBEEF, 5'd0, 5'd0, "wr7");
    cycle(1'b0, 5'd0, 32'h0, 5'd7, 5'd3, "rd7");
    cycle(1'b1, 5'd9, 32'h12345678, 5'd9, 5'd9, "bypass9");
    cycle(1'b0, 5'd0, 32'h0, 5'd9, 5'd7, "rd9");

    cycle(1'b1, 5'd0, 32'hFFFFFFFF, 5'd1, 5'd2, "wr0");
    cycle(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, "rd0");
    cycle(1'b1, 5'd0, 32'hAAAA5555, 5'd0, 5'd9, "bypass0");

    cycle(1'b1, 5'd31, 32'h31313131, 5'd30, 5'd31, "bypass_p1");
    cycle(1'b1, 5'd30, 32'h30303030, 5'd30, 5'd31, "bypass_p0");

    for (int i = 0; i < 40; i++) begin
      wa = 5'($urandom_range(31));
      ra = 5'($urandom_range(31));
      rb = 5'($urandom_range(31));
      wd = $urandom;
      cycle(1'($urandom_range(1)), wa, wd, ra, rb, "rand");
    end

    // Reset in READY with a concurrent write, then a restart mid-sweep
    rst = 1'b1; we = 1'b1; waddr = 5'd12; wdata = 32'h55555555;
    @(posedge clk); #1;
    chk("rst_ready.busy", {31'b0, busy}, 32'h1);
    chk("rst_ready.rd0", rdata0, 32'h0);
    chk("rst_ready.rd1", rdata1, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; waddr = 5'd5; wdata = 32'h77777777;
    repeat (10) begin @(posedge clk); #1; end
    chk("mid.busy_before", {31'b0, busy}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sweep(32, "sweep_mid");
    we = 1'b0;
    cycle(1'b0, 5'd0, 32'h0, 5'd5, 5'd12, "mid_rd5");

    // Small instance: DATA_W=8, ADDR_W=3
    s_rst = 1'b0;
    n = 0;
    while (s_busy === 1'b1 && n < 16) begin
      @(posedge clk); #1;
      n++;
    end
    chk("small.busy_len", n, 32'd8);
    s_we = 1'b1; s_waddr = 3'd7; s_wdata = 8'hA5; s_ra1 = 3'd6;
    @(posedge clk); #1;
    s_we = 1'b0; s_ra0 = 3'd7;
    @(posedge clk); #1;
    chk("small.rd7", {24'b0, s_rd0}, 32'h000000A5);
    chk("small.rd6", {24'b0, s_rd1}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w.md
REGFILE_2R1W -- requirements
Module: regfile_2r1w

Interface
REQ-001 SHALL have parameter DATA_W, default 32, giving the entry and read/write data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, giving the address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port we  input  1  write enable.
REQ-006 SHALL have port waddr  input  ADDR_W  write address.
REQ-007 SHALL have port wdata  input  DATA_W  write data.
REQ-008 SHALL have port raddr0  input  ADDR_W  read port 0 address.
REQ-009 SHALL have port raddr1  input  ADDR_W  read port 1 address.
REQ-010 SHALL have port rdata0  output  DATA_W  read port 0 data, registered.
REQ-011 SHALL have port rdata1  output  DATA_W  read port 1 data, registered.
REQ-012 SHALL have port busy  output  1  high while the post-reset clear sweep runs; writes and reads are not serviced.

Function
REQ-013 SHALL implement a two-state FSM: CLEAR and READY.
REQ-014 In CLEAR, each rising edge SHALL write zero to entry clr_cnt and then increment clr_cnt (ADDR_W+1 bits wide).
REQ-015 CLEAR SHALL move to READY on the edge that clears entry DEPTH-1; busy SHALL go low on that same edge.
REQ-016 In CLEAR, we SHALL be ignored and rdata0/rdata1 SHALL be held at 0.
REQ-017 In READY, when we=1, the entry at waddr SHALL be written with wdata on the rising edge.
REQ-018 In READY, each edge SHALL load rdataN with the contents of entry raddrN: read latency 1 cycle, read every cycle with no enable.
REQ-019 If we=1 and waddr==raddrN in the same cycle, rdataN SHALL load wdata (write-first bypass), independently per port.
REQ-020 Both ports reading the same address SHALL return identical data.
REQ-021 Addresses are full-range; there SHALL be no out-of-range condition and no wrap logic beyond ADDR_W truncation.

Reset
REQ-022 While rst=1, on each edge the FSM SHALL enter CLEAR, with clr_cnt=0, busy=1, rdata0=0, rdata1=0.
REQ-023 Array contents SHALL NOT be modified by rst itself; zeroing is performed only by the sweep.
REQ-024 After rst deasserts, busy SHALL remain 1 for exactly DEPTH cycles.
REQ-025 rst asserted mid-sweep SHALL restart the sweep from entry 0.
REQ-026 rst asserted in READY SHALL discard a concurrent write.

Configuration
REQ-027 Macro REGFILE_ZERO_REG_EN, when defined, SHALL make entry 0 read as constant zero.
REQ-028 With REGFILE_ZERO_REG_EN defined, writes to address 0 SHALL be dropped, reads of address 0 SHALL return 0, and the bypass SHALL never forward for address 0.
REQ-029 Without REGFILE_ZERO_REG_EN, entry 0 SHALL behave as an ordinary entry.

Verification
REQ-030 Reset sweep: pulse rst for 2 cycles, then release -> busy=1 for exactly 32 cycles; afterwards reads of addresses 0..31 return 0.
REQ-031 Write then read: write 0xDEADBEEF to address 7, then next cycle set raddr0=7 -> rdata0=0xDEADBEEF one cycle later; rdata1 with raddr1=3 returns 0.
REQ-032 Bypass: we=1, waddr=9, wdata=0x12345678, raddr0=raddr1=9 in the same cycle -> both rdata0 and rdata1 = 0x12345678 on the next edge.
REQ-033 Mid-sweep reset: assert rst at sweep cycle 10 -> busy stays 1 for 32 more cycles after release; a write issued during busy is lost and address 5 reads 0.
REQ-034 Zero register (run with and without the macro): write 0xFFFFFFFF to address 0, then read -> 0 with REGFILE_ZERO_REG_EN defined, 0xFFFFFFFF without.
REQ-035 Parameter sweep: with DATA_W=8 and ADDR_W=3, busy lasts 8 cycles; write 0xA5 to address 7 and read back 0xA5.
